// File: rtl/sequential_subtractor.sv
// Bit-serial decrementer: result = number - 1, resolved LSB first, one bit per clock.
// Operand taken over valid/ready, result held in DONE until the consumer takes it.
//
// state  | meaning
// IDLE   | ready for an operand; res/uflow hold the last result
// BORROW | borrow still pending, each bit is inverted
// COPY   | borrow resolved, remaining bits copied through
// DONE   | result and underflow valid until out_ready
module sequential_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] number,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             underflow
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BORROW = 2'd1,
    COPY   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] res;
  logic [IDX_W-1:0] idx;
  logic             uflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      opnd  <= '0;
      res   <= '0;
      idx   <= '0;
      uflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opnd  <= number;
            res   <= '0;
            idx   <= '0;
            uflow <= 1'b0;
            state <= BORROW;
          end
        end
        BORROW: begin
          // A set bit absorbs the borrow; a clear bit becomes 1 and passes it on.
          res[idx] <= ~opnd[idx];
          if (opnd[idx]) state <= COPY;
          if (idx == LAST_IDX) begin
            state <= DONE;
            idx   <= '0;
            uflow <= ~opnd[idx];
          end else begin
            idx <= idx + 1'b1;
          end
        end
        COPY: begin
          res[idx] <= opnd[idx];
          if (idx == LAST_IDX) begin
            state <= DONE;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = res;
  assign underflow = uflow;

endmodule

// File: tb/tb_sequential_subtractor.sv
// Self-checking bench for sequential_subtractor at WIDTH=4 (directed) and WIDTH=8 (full sweep).
// An arithmetic handshake model is compared against both instances every cycle.
module tb_sequential_subtractor;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       iv4 = 1'b0, or4 = 1'b1;
  logic       ir4, ov4, uf4;
  logic [3:0] num4 = '0;
  logic [3:0] res4;

  logic       iv8 = 1'b0, or8 = 1'b1;
  logic       ir8, ov8, uf8;
  logic [7:0] num8 = '0;
  logic [7:0] res8;

  sequential_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4), .number(num4),
    .out_valid(ov4), .out_ready(or4), .result(res4), .underflow(uf4)
  );

  sequential_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .number(num8),
    .out_valid(ov8), .out_ready(or8), .result(res8), .underflow(uf8)
  );

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 = idle, 1 = busy for WIDTH cycles, 2 = result presented.
  int         wv[2] = '{4, 8};
  int         m_phase[2];
  int         m_cnt[2];
  logic [7:0] m_opnd[2];
  logic [7:0] m_res[2];
  bit         m_uf[2];

  task automatic model_step(input int d, input bit rst, input bit iv, input logic [7:0] num, input bit ordy);
    logic [7:0] mask;
    mask = 8'((1 << wv[d]) - 1);
    if (rst) begin
      m_phase[d] = 0;
      m_cnt[d]   = 0;
      m_res[d]   = '0;
      m_uf[d]    = 1'b0;
    end else begin
      case (m_phase[d])
        0: if (iv) begin
          m_opnd[d]  = num & mask;
          m_cnt[d]   = 0;
          m_phase[d] = 1;
        end
        1: begin
          m_cnt[d]++;
          if (m_cnt[d] == wv[d]) begin
            m_phase[d] = 2;
            m_res[d]   = (m_opnd[d] - 8'd1) & mask;
            m_uf[d]    = (m_opnd[d] == 8'd0);
          end
        end
        default: if (ordy) m_phase[d] = 0;
      endcase
    end
  endtask

  always @(posedge clk or posedge reset) begin
    model_step(0, reset, iv4, {4'b0, num4}, or4);
    model_step(1, reset, iv8, num8, or8);
  end

  task automatic cmp(input int d, input logic ir, input logic ov, input logic [7:0] r, input logic u);
    chk($sformatf("w%0d_in_ready", wv[d]), 32'(ir), 32'(m_phase[d] == 0));
    chk($sformatf("w%0d_out_valid", wv[d]), 32'(ov), 32'(m_phase[d] == 2));
    if (m_phase[d] != 1) begin
      chk($sformatf("w%0d_result", wv[d]), 32'(r), 32'(m_res[d]));
      chk($sformatf("w%0d_underflow", wv[d]), 32'(u), 32'(m_uf[d]));
    end
  endtask

  always @(negedge clk) begin
    if (armed && !reset) begin
      cmp(0, ir4, ov4, {4'b0, res4}, uf4);
      cmp(1, ir8, ov8, res8, uf8);
    end
  end

  task automatic run4(input logic [3:0] x, input logic [3:0] exp_r, input logic exp_u);
    int n;
    @(negedge clk);
    num4 = x;
    iv4  = 1'b1;
    n = 0;
    while (!ir4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("run4_accept_wait", 32'(ir4), 32'(1));
    @(posedge clk);
    #1 iv4 = 1'b0;
    n = 0;
    while (!ov4 && n < 20) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk($sformatf("run4_latency_%b", x), 32'(n), 32'(4));
    chk($sformatf("run4_result_%b", x), 32'(res4), 32'(exp_r));
    chk($sformatf("run4_underflow_%b", x), 32'(uf4), 32'(exp_u));
  endtask

  task automatic wait_idle4();
    int n;
    n = 0;
    while (!ir4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle4_wait", 32'(ir4), 32'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int prev;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(ir4), 32'(1));
    chk("rst_out_valid", 32'(ov4), 32'(0));
    chk("rst_result", 32'(res4), 32'(0));
    chk("rst_underflow", 32'(uf4), 32'(0));
    chk("rst_w8_result", 32'(res8), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    armed = 1'b1;

    run4(4'b1000, 4'b0111, 1'b0);
    run4(4'b0001, 4'b0000, 1'b0);
    run4(4'b1111, 4'b1110, 1'b0);
    run4(4'b0000, 4'b1111, 1'b1);
    run4(4'b0101, 4'b0100, 1'b0);

    // Backpressure with a changing operand and a stray in_valid while busy.
    wait_idle4();
    or4 = 1'b0;
    num4 = 4'b0110;
    iv4  = 1'b1;
    @(posedge clk);
    #1 num4 = 4'b1111;
    @(posedge clk);
    @(posedge clk);
    #1 iv4 = 1'b0;
    n = 0;
    while (!ov4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", 32'(ov4), 32'(1));
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready_low", 32'(ir4), 32'(0));
      chk("bp_result_stable", 32'(res4), 32'(4'b0101));
      chk("bp_underflow", 32'(uf4), 32'(0));
    end
    @(negedge clk);
    or4 = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_in_ready_after", 32'(ir4), 32'(1));

    // Reset during bit cycle 2.
    wait_idle4();
    num4 = 4'b1010;
    iv4  = 1'b1;
    @(posedge clk);
    #1 iv4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(ov4), 32'(0));
    chk("midrst_in_ready", 32'(ir4), 32'(1));
    chk("midrst_result", 32'(res4), 32'(0));
    chk("midrst_underflow", 32'(uf4), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("midrst_no_out_valid", 32'(ov4), 32'(0));
    end
    run4(4'b0011, 4'b0010, 1'b0);

    // WIDTH=8 back-to-back sweep.
    or8  = 1'b1;
    iv8  = 1'b1;
    prev = 0;
    for (int x = 0; x < 256; x++) begin
      @(negedge clk);
      num8 = 8'(x);
      n = 0;
      while (!ir8 && n < 30) begin
        @(negedge clk);
        n++;
      end
      chk("sweep_accept_wait", 32'(ir8), 32'(1));
      if (x > 0) chk("sweep_period", 32'(cyc - prev), 32'(10));
      prev = cyc;
      @(posedge clk);
      #1;
    end
    iv8 = 1'b0;
    n = 0;
    while (!ov8 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("sweep_last_valid", 32'(ov8), 32'(1));
    chk("sweep_last_result", 32'(res8), 32'(8'hFE));
    chk("sweep_last_underflow", 32'(uf8), 32'(0));
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
